// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller and its helpers.
package pipe_pkg;

    localparam int unsigned REGW = 5;
    localparam logic [REGW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } fsm_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard terms (load-use, taken branch, memory stall); shareable with a forwarding unit.
module pipe_hazard_detect
    import pipe_pkg::*;
(
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_wn,
    input  logic            mem_branch,
    input  logic            mem_zero,
    input  logic            mem_memop,
    input  logic            dmem_ready,
    output logic            loaduse_c,
    output logic            brtaken_c,
    output logic            memstall_c
);

    // $0 is never a real producer, so a load targeting it cannot create a hazard
    assign loaduse_c  = ex_memread && (ex_wn != REG_ZERO) &&
                        ((ex_wn == id_rs) || (id_uses_rt && (ex_wn == id_rt)));
    assign brtaken_c  = mem_branch & mem_zero;
    assign memstall_c = mem_memop & ~dmem_ready;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline with data-memory wait tracking.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64
`ifdef PIPE_HAZARD_PERF_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_uses_rt,
    input  logic            ex_memread,
    input  logic [REGW-1:0] ex_wn,
    input  logic            mem_branch,
    input  logic            mem_zero,
    input  logic            mem_memop,
    input  logic            dmem_ready,
    output logic            pc_en,
    output logic            en_if_id,
    output logic            en_id_ex,
    output logic            en_ex_mem,
    output logic            en_mem_wb,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            flush_ex_mem,
    output logic            pc_src_branch,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic            mem_err
);

    localparam int unsigned WCW = 8;

    fsm_e           fsm_q, fsm_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           mem_err_q, mem_err_d;
    logic           loaduse_c, brtaken_c, memstall_c;
    logic           freeze_c, br_svc_c;

    pipe_hazard_detect u_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_wn      (ex_wn),
        .mem_branch (mem_branch),
        .mem_zero   (mem_zero),
        .mem_memop  (mem_memop),
        .dmem_ready (dmem_ready),
        .loaduse_c  (loaduse_c),
        .brtaken_c  (brtaken_c),
        .memstall_c (memstall_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // ERR freezes the pipe regardless of inputs; otherwise an outstanding access does
    assign freeze_c = (fsm_q == ERR) || memstall_c;
    assign br_svc_c = !freeze_c && brtaken_c;

    always_comb begin
        fsm_d         = fsm_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;
        pc_en         = 1'b1;
        en_if_id      = 1'b1;
        en_id_ex      = 1'b1;
        en_ex_mem     = 1'b1;
        en_mem_wb     = 1'b1;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        pc_src_branch = 1'b0;

        unique case (fsm_q)
            RUN: begin
                if (memstall_c) begin
                    fsm_d      = MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end
            end
            MEM_WAIT: begin
                if (!memstall_c) begin
                    fsm_d      = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                    if (wait_cnt_d == WCW'(MEM_TIMEOUT)) begin
                        fsm_d     = ERR;
                        mem_err_d = 1'b1;
                    end
                end
            end
            ERR: mem_err_d = 1'b1;
            default: fsm_d = RUN;
        endcase

        if (freeze_c) begin
            pc_en     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
        end else if (br_svc_c) begin
            // squash the three younger instructions; any load-use among them is moot
            pc_src_branch = 1'b1;
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            flush_ex_mem  = 1'b1;
        end else if (loaduse_c) begin
            pc_en       = 1'b0;
            en_if_id    = 1'b0;
            flush_id_ex = 1'b1;
        end
    end

    assign mem_err = mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // saturating counters: hold at all-ones instead of wrapping
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (br_svc_c && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4; perf counters checked when PIPE_HAZARD_PERF_EN).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_wn;
    logic       id_uses_rt, ex_memread, mem_branch, mem_zero, mem_memop, dmem_ready;
    logic       pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic       flush_if_id, flush_id_ex, flush_ex_mem, pc_src_branch, mem_err;
`ifdef PIPE_HAZARD_PERF_EN
    logic [1:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem, pc_src_branch, mem_err}
    localparam logic [9:0] C_RUN    = 10'b11111_000_0_0;
    localparam logic [9:0] C_LU     = 10'b00111_010_0_0;
    localparam logic [9:0] C_BR     = 10'b11111_111_1_0;
    localparam logic [9:0] C_FREEZE = 10'b00000_000_0_0;
    localparam logic [9:0] C_ERR    = 10'b00000_000_0_1;

    logic [9:0] ctrl;
    assign ctrl = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                   flush_if_id, flush_id_ex, flush_ex_mem, pc_src_branch, mem_err};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4)
`ifdef PIPE_HAZARD_PERF_EN
        , .CNT_W     (2)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_memread    (ex_memread),
        .ex_wn         (ex_wn),
        .mem_branch    (mem_branch),
        .mem_zero      (mem_zero),
        .mem_memop     (mem_memop),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .en_if_id      (en_if_id),
        .en_id_ex      (en_id_ex),
        .en_ex_mem     (en_ex_mem),
        .en_mem_wb     (en_mem_wb),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .flush_ex_mem  (flush_ex_mem),
        .pc_src_branch (pc_src_branch),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .mem_err       (mem_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                          input logic memread, input logic [4:0] wn, input logic br,
                          input logic zero, input logic memop, input logic rdy);
        id_rs      = rs;
        id_rt      = rt;
        id_uses_rt = uses_rt;
        ex_memread = memread;
        ex_wn      = wn;
        mem_branch = br;
        mem_zero   = zero;
        mem_memop  = memop;
        dmem_ready = rdy;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("reset_ctrl", 32'(ctrl), 32'(C_RUN));
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("idle_run", 32'(ctrl), 32'(C_RUN));

        // load-use on rs: one bubble, then load has moved on
        set_in(8, 0, 0, 1, 8, 0, 0, 0, 0);
        check_eq("loaduse_rs", 32'(ctrl), 32'(C_LU));
        step();
        set_in(8, 0, 0, 0, 8, 0, 0, 0, 0);
        check_eq("loaduse_after", 32'(ctrl), 32'(C_RUN));
`ifdef PIPE_HAZARD_PERF_EN
        check_eq("perf_stall_1", 32'(stall_cnt), 32'd1);
`endif

        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0);
        check_eq("loaduse_r0_exempt", 32'(ctrl), 32'(C_RUN));
        set_in(3, 9, 0, 1, 9, 0, 0, 0, 0);
        check_eq("loaduse_rt_unused", 32'(ctrl), 32'(C_RUN));
        set_in(3, 9, 1, 1, 9, 0, 0, 0, 0);
        check_eq("loaduse_rt_used", 32'(ctrl), 32'(C_LU));
        set_in(3, 9, 1, 1, 9, 1, 0, 0, 0);
        check_eq("branch_not_taken", 32'(ctrl), 32'(C_LU));

        // taken branch with a concurrent load-use
        set_in(8, 0, 0, 1, 8, 1, 1, 0, 0);
        check_eq("branch_over_loaduse", 32'(ctrl), 32'(C_BR));
        step();
`ifdef PIPE_HAZARD_PERF_EN
        check_eq("perf_flush_1", 32'(flush_cnt), 32'd1);
`endif

        // single-cycle memop: no stall, no state change
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check_eq("memop_fast", 32'(ctrl), 32'(C_RUN));
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("memop_fast_after", 32'(ctrl), 32'(C_RUN));

        // three stalled cycles with a taken branch pending behind the access
        set_in(8, 0, 0, 1, 8, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("memwait_%0d", i), 32'(ctrl), 32'(C_FREEZE));
            step();
        end
        set_in(8, 0, 0, 1, 8, 1, 1, 1, 1);
        check_eq("memwait_ready_branch", 32'(ctrl), 32'(C_BR));
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("memwait_back_run", 32'(ctrl), 32'(C_RUN));
`ifdef PIPE_HAZARD_PERF_EN
        check_eq("perf_stall_sat", 32'(stall_cnt), 32'd3);
        check_eq("perf_flush_2", 32'(flush_cnt), 32'd2);
`endif

        // fresh stall after recovery: counter restarted, so 3 stalls stay below timeout
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step();
        check_eq("timeout_pre", 32'(ctrl), 32'(C_FREEZE));
        step();
        check_eq("timeout_err", 32'(ctrl), 32'(C_ERR));
        set_in(0, 0, 0, 0, 0, 1, 1, 1, 1);
        check_eq("err_ignores_ready", 32'(ctrl), 32'(C_ERR));
        step();
        check_eq("err_sticky", 32'(ctrl), 32'(C_ERR));

        // asynchronous reset away from a clock edge
        #1 rst = 1'b0;
        #1;
        check_eq("err_async_reset", 32'(ctrl), 32'(C_BR));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("reset_mem_err", 32'(mem_err), 32'd0);
        step();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        check_eq("post_reset_stall", 32'(ctrl), 32'(C_FREEZE));
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        check_eq("post_reset_ready", 32'(ctrl), 32'(C_RUN));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
